// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel byte and strobes out.
`timescale 1ns/1ps
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  modport master (output rx, input rx_data, rx_valid, rx_err, rx_busy);
  modport slave  (input rx, output rx_data, rx_valid, rx_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge, samples each bit
// at its centre and emits a one-cycle valid or framing-error strobe.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_cfg_err
    $error("uart_rx: CLKS_PER_BIT must be >= 8");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;

  // Synchronizer resets high so a released reset never looks like a start edge
  // on an idle line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Requires a fresh 1->0 transition; a line held low never retriggers.
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_err   = err_q;
  assign bus.rx_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, glitch, and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 3_125_000;
  localparam int  CPB      = 16;
  localparam time CLK_T    = 20;
  localparam time BIT_T    = CPB * CLK_T;

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #(CLK_T / 2) clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         n_valid = 0;
  int         n_err   = 0;
  int         n_both  = 0;
  logic [7:0] got_data[$];
  time        got_time[$];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid++;
      got_data.push_back(bus.rx_data);
      got_time.push_back($time);
    end
    if (bus.rx_err) n_err++;
    if (bus.rx_valid && bus.rx_err) n_both++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    #(BIT_T);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_bits;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, e0, busy_cnt;
    time dt;

    vecs[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5};
    vecs[1] = '{8'hFF, 1'b0, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 0, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    vecs[5] = '{8'h6E, 1'b1, 0, 1, 0, 8'h6E};

    bus.rx = 1'b1;
    #(3 * CLK_T + 3);
    check("reset rx_data",  int'(bus.rx_data),  0);
    check("reset rx_valid", int'(bus.rx_valid), 0);
    check("reset rx_err",   int'(bus.rx_err),   0);
    check("reset rx_busy",  int'(bus.rx_busy),  0);
    rst = 1'b1;
    #(2 * BIT_T);

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].low_bits > 0) begin
        bus.rx = 1'b0;
        #(vecs[i].low_bits * BIT_T);
        bus.rx = 1'b1;
      end
      #(2 * BIT_T);
      check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d err count", i),   n_err - e0,   vecs[i].exp_err);
      check($sformatf("vec%0d rx_data", i),     int'(bus.rx_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d rx_busy", i),     int'(bus.rx_busy), 0);
    end

    // Back-to-back frames, no idle between stop and next start.
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h5A, 1'b1);
    send_frame(8'h00, 1'b1);
    #(2 * BIT_T);
    check("b2b valid count", n_valid - v0, 2);
    check("b2b err count",   n_err - e0,   0);
    if (n_valid - v0 == 2) begin
      check("b2b first byte",  int'(got_data[got_data.size()-2]), 8'h5A);
      check("b2b second byte", int'(got_data[got_data.size()-1]), 8'h00);
      dt = got_time[got_time.size()-1] - got_time[got_time.size()-2];
      check("b2b spacing clocks", int'(dt / CLK_T), 10 * CPB);
    end

    // Short low glitch: must be rejected at mid start bit.
    v0 = n_valid;
    e0 = n_err;
    busy_cnt = 0;
    bus.rx = 1'b0;
    #(3 * CLK_T);
    bus.rx = 1'b1;
    for (int c = 0; c < 2 * CPB; c++) begin
      @(negedge clk);
      if (bus.rx_busy) busy_cnt++;
    end
    check("glitch valid count", n_valid - v0, 0);
    check("glitch err count",   n_err - e0,   0);
    check("glitch busy seen",   int'(busy_cnt > 0), 1);
    check("glitch busy bound",  int'(busy_cnt <= CPB / 2 + 3), 1);
    send_frame(8'h3C, 1'b1);
    #(2 * BIT_T);
    check("post-glitch valid", n_valid - v0, 1);
    check("post-glitch data",  int'(bus.rx_data), 8'h3C);

    // Reset during the 4th data bit of 8'hC3.
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.rx = 1'b0;
    #(BIT_T / 2);
    rst = 1'b0;
    #(CLK_T / 2);
    check("midreset rx_data",  int'(bus.rx_data),  0);
    check("midreset rx_busy",  int'(bus.rx_busy),  0);
    check("midreset rx_valid", int'(bus.rx_valid), 0);
    bus.rx = 1'b1;
    #(2 * BIT_T);
    rst = 1'b1;
    #(2 * BIT_T);
    check("midreset no valid", n_valid - v0, 0);
    check("midreset no err",   n_err - e0,   0);
    send_frame(8'h96, 1'b1);
    #(2 * BIT_T);
    check("post-reset valid", n_valid - v0, 1);
    check("post-reset data",  int'(bus.rx_data), 8'h96);
    check("valid/err overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream counterpart of the existing tx serializer. It consumes the serial line that tx drives.
- Frame format: 8N1, LSB first, idle high.
- Recovers each byte by mid-bit sampling against a baud counter derived from the 50 MHz system clock.
- Presents each byte on a parallel bus with a one-cycle valid strobe, plus a framing-error strobe.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clocks per bit (derived localparam). Must be >= 8; a smaller value is a configuration error.

Ports:
- clk     input   1  system clock, rising edge.
- rst     input   1  asynchronous active-low reset.
- rx      input   1  serial line, asynchronous to clk, idle high.
- rx_data output  8  last correctly framed byte.
- rx_valid output 1  one-cycle pulse: rx_data updated this cycle.
- rx_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- rx_busy output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset: clk, one clock; rst asynchronous, active-low.
- Reset values: rx_data=8'h00, rx_valid=0, rx_err=0, rx_busy=0. Synchronizer flops=1, state=IDLE, bit counter=0, baud counter=0.
- Input synchronization:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - A third flop rx_d gives edge detection.
  - Nothing samples rx directly.
- Baud counter: counts 0..CLKS_PER_BIT-1; it is cleared on every state transition.
- State machine:
  - IDLE: start edge = rx_d==1 && rx_s==0 -> START, rx_busy=1. A line held low never retriggers; a fresh 1->0 transition is required.
  - START: at count==CLKS_PER_BIT/2-1 (mid start bit), rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch rejection, no strobes).
  - DATA: at count==CLKS_PER_BIT-1 (each bit centre), shift rx_s into shift_reg MSB, shift right (LSB first). After the 8th sample -> STOP.
  - STOP: at count==CLKS_PER_BIT-1:
    - rx_s==1: rx_data<=shift_reg, rx_valid=1 for exactly one cycle.
    - rx_s==0: rx_err=1 for one cycle, rx_data unchanged.
    - Either case -> IDLE, rx_busy=0.
- Mid-stop-bit return: the return to IDLE happens at mid stop bit, which allows back-to-back frames with zero idle time at up to about 2% baud mismatch.
- Latency: rx_valid asserts 9.5 bit times + 3..4 clocks after the rx falling edge at the pin.
- rx_valid and rx_err are never high in the same cycle. Both are registered outputs.
- Break condition (line held low): produces one rx_err, then waits in IDLE until the line returns high and falls again.
- Reset mid-frame: all state is dropped immediately (asynchronous). No strobe is issued for the partial frame. After release, the receiver looks for a new 1->0 edge.
- No buffering: a byte not consumed before the next rx_valid is overwritten. The consumer must take rx_data on the rx_valid cycle.

Test Plan:
- Single byte: 8'hA5 driven at 104166 ns/bit after reset release -> exactly one rx_valid pulse, rx_data=8'hA5, rx_err never high, rx_busy low afterward.
- Back-to-back: 8'h5A then 8'h00 with no idle between stop and next start -> two rx_valid pulses, rx_data=8'h5A then 8'h00, about 10 bit times apart.
- Glitch rejection: rx low for 1000 ns (50 clocks) then high -> no rx_valid, no rx_err, rx_busy high at most CLKS_PER_BIT/2+3 clocks. A following 8'h3C frame is still received correctly.
- Framing error: 8'hFF frame with stop bit forced low, line held low 2 bit times, then high. Expected: one rx_err pulse, no rx_valid, rx_data retains the prior value (8'hA5). A subsequent 8'h81 frame is received correctly.
- Reset mid-frame: assert rst low during the 4th data bit of 8'hC3, release, then send 8'h96 -> no strobes for 8'hC3, outputs at reset values during reset, rx_data=8'h96 afterward.
- Loopback: the tx module's tx output drives rx. tx_data=8'hA5, then 8'h5A -> rx_valid pulses with rx_data=8'hA5, then 8'h5A, and rx_err stays 0.
